// File: rtl/gate_response_checker_pkg.sv
// Shared encodings for the gate response checker: reference-function codes and FSM states.
package gate_response_checker_pkg;

  localparam logic [1:0] FUNC_AND  = 2'b00;
  localparam logic [1:0] FUNC_OR   = 2'b01;
  localparam logic [1:0] FUNC_XOR  = 2'b10;
  localparam logic [1:0] FUNC_NAND = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/gate_response_checker_if.sv
// Sample/control/result bundle between the test sequencer (master) and the checker (slave).
interface gate_response_checker_if #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8,
  parameter int SIG_W = 8
);
  logic             start;
  logic [1:0]       func;
  logic             in_valid;
  logic [N_IN-1:0]  in_vec;
  logic             out_bit;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] pat_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             first_fail_valid;
  logic [N_IN-1:0]  first_fail_vec;
  logic [SIG_W-1:0] signature;

  modport master (
    output start, func, in_valid, in_vec, out_bit,
    input  in_ready, busy, done, pass, pat_cnt, err_cnt,
           first_fail_valid, first_fail_vec, signature
  );

  modport slave (
    input  start, func, in_valid, in_vec, out_bit,
    output in_ready, busy, done, pass, pat_cnt, err_cnt,
           first_fail_valid, first_fail_vec, signature
  );
endinterface

// File: rtl/gate_response_checker_misr_compactor.sv
// Multiple-input signature register: shift-left with polynomial feedback, XOR in one word per enable.
module misr_compactor #(
  parameter int               SIG_W = 8,
  parameter logic [SIG_W-1:0] POLY  = 8'h1D
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);
  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ din;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;
endmodule

// File: rtl/gate_response_checker.sv
// Response analyser for an exhaustive gate test: counts patterns/mismatches, logs first failure, compacts to a MISR.
//   state  | meaning
//   S_IDLE | after reset, waiting for start
//   S_RUN  | accepting samples until N_PAT have been seen
//   S_DONE | results held until start or reset
module gate_response_checker
  import gate_response_checker_pkg::*;
#(
  parameter int               N_IN  = 2,
  parameter int               N_PAT = 4,
  parameter int               CNT_W = 8,
  parameter int               SIG_W = 8,
  parameter logic [SIG_W-1:0] POLY  = 8'h1D
) (
  input  logic                   CLK,
  input  logic                   RST,
  gate_response_checker_if.slave bus
);
  state_e           state_q, state_d;
  logic [1:0]       func_q, func_d;
  logic [CNT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [N_IN-1:0]  ffvec_q, ffvec_d;

  logic             accept;
  logic             run_start;
  logic             exp_bit;
  logic             mismatch;
  logic [SIG_W-1:0] misr_din;
  logic [SIG_W-1:0] sig;

  assign accept    = bus.in_valid & (state_q == S_RUN);
  assign run_start = bus.start & (state_q != S_RUN);

  always_comb begin
    exp_bit = 1'b0;
    case (func_q)
      FUNC_AND:  exp_bit = &bus.in_vec;
      FUNC_OR:   exp_bit = |bus.in_vec;
      FUNC_XOR:  exp_bit = ^bus.in_vec;
      FUNC_NAND: exp_bit = ~&bus.in_vec;
      default:   exp_bit = 1'b0;
    endcase
  end

  assign mismatch = bus.out_bit != exp_bit;

  always_comb begin
    misr_din = '0;
    misr_din[N_IN:0] = {bus.in_vec, bus.out_bit};
  end

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    pat_d   = pat_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          func_d  = bus.func;
          pat_d   = '0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          pat_d = pat_q + 1'b1;
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = bus.in_vec;
            end
          end
          if (pat_q == CNT_W'(N_PAT - 1)) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      func_q  <= FUNC_AND;
      pat_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      pat_q   <= pat_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  misr_compactor #(.SIG_W(SIG_W), .POLY(POLY)) u_misr (
    .CLK (CLK),
    .RST (RST),
    .clr (run_start),
    .en  (accept),
    .din (misr_din),
    .sig (sig)
  );

  assign bus.in_ready         = (state_q == S_RUN);
  assign bus.busy             = (state_q == S_RUN);
  assign bus.done             = (state_q == S_DONE);
  assign bus.pass             = (state_q == S_DONE) && (err_q == '0);
  assign bus.pat_cnt          = pat_q;
  assign bus.err_cnt          = err_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_vec   = ffvec_q;
  assign bus.signature        = sig;
endmodule
